// File: rtl/chunked_prefix_adder_pkg.sv
// Shared definitions for the chunked prefix adder.
//   state_t   : FSM state encoding (IDLE, RUN, DONE), 2 bits.
//   cnt_width : width of the chunk counter for K chunks, never below 1 bit.
package chunked_prefix_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int k);
    int w;
    w = $clog2(k);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/chunked_prefix_adder_if.sv
// Operand/result bus of the chunked prefix adder.
//   in_valid/in_ready   : operand handshake (a, b, c, sub)
//   out_valid/out_ready : result handshake (sum, carry_out, P_ik, G_ik)
// master drives operands and out_ready; slave is the adder.
interface chunked_prefix_adder_if #(
  parameter int N = 128
);
  import chunked_prefix_adder_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c;
  logic         sub;
  logic [N-1:0] sum;
  logic         carry_out;
  logic         P_ik;
  logic         G_ik;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output in_valid, a, b, c, sub, out_ready,
    input  in_ready, sum, carry_out, P_ik, G_ik, out_valid
  );

  modport slave (
    input  in_valid, a, b, c, sub, out_ready,
    output in_ready, sum, carry_out, P_ik, G_ik, out_valid
  );

endinterface

// File: rtl/chunked_prefix_adder_chunk_cla.sv
// Combinational W-bit carry-lookahead slice.
//   a, b : chunk operands (b already inverted for subtraction)
//   cin  : carry into the chunk
//   s    : chunk sum
//   p, g : group propagate / generate of the whole chunk (independent of cin)
//   cout : carry out of the chunk
module chunk_cla
  import chunked_prefix_adder_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         p,
  output logic         g,
  output logic         cout
);

  logic [W-1:0] pb;
  logic [W-1:0] gb;
  logic [W-1:0] ppre;
  logic [W-1:0] gpre;
  logic [W-1:0] carry;

  assign pb = a ^ b;
  assign gb = a & b;

  // Prefix terms over bits [i:0]; every bit's carry is then formed directly
  // from a prefix term and cin, so cin never ripples through the slice.
  always_comb begin
    ppre    = '0;
    gpre    = '0;
    carry   = '0;
    ppre[0] = pb[0];
    gpre[0] = gb[0];
    for (int i = 1; i < W; i++) begin
      ppre[i] = pb[i] & ppre[i-1];
      gpre[i] = gb[i] | (pb[i] & gpre[i-1]);
    end
    carry[0] = cin;
    for (int i = 1; i < W; i++) begin
      carry[i] = gpre[i-1] | (ppre[i-1] & cin);
    end
  end

  assign s    = pb ^ carry;
  assign p    = ppre[W-1];
  assign g    = gpre[W-1];
  assign cout = gpre[W-1] | (ppre[W-1] & cin);

endmodule

// File: rtl/chunked_prefix_adder.sv
// Multi-cycle N-bit adder/subtractor processing W bits per cycle, low chunk
// first, through a single chunk_cla slice.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of chunked_prefix_adder_if
//                operands a, b, c, sub accepted on in_valid && in_ready;
//                sum, carry_out, P_ik, G_ik held while out_valid until out_ready.
// N must be a multiple of W. Latency from acceptance to out_valid is N/W edges.
module chunked_prefix_adder
  import chunked_prefix_adder_pkg::*;
#(
  parameter int N = 128,
  parameter int W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  chunked_prefix_adder_if.slave  bus
);

  localparam int K  = N / W;
  localparam int CW = cnt_width(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  sum_q;
  logic          cry;
  logic          p_acc;
  logic          g_acc;
  logic          in_ready;
  logic          out_valid;

  logic [W-1:0]  a_k;
  logic [W-1:0]  b_k;
  logic [W-1:0]  s_k;
  logic          p_k;
  logic          g_k;
  logic          cout_k;

  assign a_k = a_q[int'(cnt)*W +: W];
  assign b_k = b_q[int'(cnt)*W +: W];

  chunk_cla #(.W(W)) u_slice (
    .a    (a_k),
    .b    (b_k),
    .cin  (cry),
    .s    (s_k),
    .p    (p_k),
    .g    (g_k),
    .cout (cout_k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nx = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operands are captured on acceptance so the caller may change them freely
  // afterwards. The flag outputs are the accumulators themselves: they stop
  // changing once the last chunk is folded in, which keeps them stable in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      cry   <= 1'b0;
      p_acc <= 1'b0;
      g_acc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.sub ? ~bus.b : bus.b;
            cry   <= bus.sub ? 1'b1 : bus.c;
            cnt   <= '0;
            p_acc <= 1'b1;
            g_acc <= 1'b0;
          end
        end
        RUN: begin
          sum_q[int'(cnt)*W +: W] <= s_k;
          cry   <= cout_k;
          p_acc <= p_k & p_acc;
          g_acc <= g_k | (p_k & g_acc);
          if (cnt != LAST) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cry;
  assign bus.P_ik      = p_acc;
  assign bus.G_ik      = g_acc;

endmodule

// File: tb/tb_chunked_prefix_adder.sv
// Testbench for chunked_prefix_adder: four instances (128/32, 16/4, 8/8, 8/1)
// sharing clock and reset, scoreboarded against a plain-arithmetic model.
module tb_chunked_prefix_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [127:0] sum;
    logic         cout;
    logic         p;
    logic         g;
    logic         cin;
  } exp_t;

  exp_t q128[$];
  exp_t q16[$];
  exp_t q8a[$];
  exp_t q8b[$];

  chunked_prefix_adder_if #(.N(128)) i128 ();
  chunked_prefix_adder_if #(.N(16))  i16  ();
  chunked_prefix_adder_if #(.N(8))   i8a  ();
  chunked_prefix_adder_if #(.N(8))   i8b  ();

  chunked_prefix_adder #(.N(128), .W(32)) d128 (.clk(clk), .rst_n(rst_n), .bus(i128));
  chunked_prefix_adder #(.N(16),  .W(4))  d16  (.clk(clk), .rst_n(rst_n), .bus(i16));
  chunked_prefix_adder #(.N(8),   .W(8))  d8a  (.clk(clk), .rst_n(rst_n), .bus(i8a));
  chunked_prefix_adder #(.N(8),   .W(1))  d8b  (.clk(clk), .rst_n(rst_n), .bus(i8b));

  // Reference: the whole N-bit operation done with one wide addition.
  // G is the carry out with zero carry-in, P is "every bit position propagates".
  function automatic exp_t model(input int n, input logic [127:0] a, input logic [127:0] b,
                                 input logic c, input logic sub);
    exp_t         r;
    logic [128:0] full;
    logic [128:0] gen;
    logic [127:0] mask;
    logic [127:0] am;
    logic [127:0] bm;
    mask  = (n >= 128) ? {128{1'b1}} : ((128'd1 << n) - 128'd1);
    am    = a & mask;
    bm    = (sub ? ~b : b) & mask;
    r.cin = sub ? 1'b1 : c;
    full  = {1'b0, am} + {1'b0, bm} + {128'd0, r.cin};
    gen   = {1'b0, am} + {1'b0, bm};
    r.sum  = full[127:0] & mask;
    r.cout = full[n];
    r.g    = gen[n];
    r.p    = ((am ^ bm) == mask);
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon128
    exp_t e;
    if (rst_n && i128.out_valid && i128.out_ready) begin
      if (q128.size() == 0) flag_fail("mon128_unexpected_result");
      else begin
        e = q128.pop_front();
        check("sum128", i128.sum, e.sum);
        check_b("cout128", i128.carry_out, e.cout);
        check_b("P128", i128.P_ik, e.p);
        check_b("G128", i128.G_ik, e.g);
        check_b("inv128", i128.carry_out, i128.G_ik | (i128.P_ik & e.cin));
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (rst_n && i16.out_valid && i16.out_ready) begin
      if (q16.size() == 0) flag_fail("mon16_unexpected_result");
      else begin
        e = q16.pop_front();
        check("sum16", {112'd0, i16.sum}, e.sum);
        check_b("cout16", i16.carry_out, e.cout);
        check_b("P16", i16.P_ik, e.p);
        check_b("G16", i16.G_ik, e.g);
      end
    end
  end

  always @(negedge clk) begin : mon8a
    exp_t e;
    if (rst_n && i8a.out_valid && i8a.out_ready) begin
      if (q8a.size() == 0) flag_fail("mon8a_unexpected_result");
      else begin
        e = q8a.pop_front();
        check("sum8a", {120'd0, i8a.sum}, e.sum);
        check_b("cout8a", i8a.carry_out, e.cout);
        check_b("P8a", i8a.P_ik, e.p);
        check_b("G8a", i8a.G_ik, e.g);
      end
    end
  end

  always @(negedge clk) begin : mon8b
    exp_t e;
    if (rst_n && i8b.out_valid && i8b.out_ready) begin
      if (q8b.size() == 0) flag_fail("mon8b_unexpected_result");
      else begin
        e = q8b.pop_front();
        check("sum8b", {120'd0, i8b.sum}, e.sum);
        check_b("cout8b", i8b.carry_out, e.cout);
        check_b("P8b", i8b.P_ik, e.p);
        check_b("G8b", i8b.G_ik, e.g);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic op128(input logic [127:0] a, input logic [127:0] b,
                       input logic c, input logic sub, input int stall);
    int g;
    int lat;
    i128.a = a; i128.b = b; i128.c = c; i128.sub = sub;
    i128.out_ready = (stall == 0);
    i128.in_valid  = 1'b1;
    g = 0;
    while (!i128.in_ready && g < 20) begin @(posedge clk); #1; g++; end
    if (g >= 20) flag_fail("in_ready128_timeout");
    q128.push_back(model(128, a, b, c, sub));
    @(posedge clk); #1;
    i128.in_valid = 1'b0;
    i128.a   = {$urandom(), $urandom(), $urandom(), $urandom()};
    i128.b   = {$urandom(), $urandom(), $urandom(), $urandom()};
    i128.c   = 1'($urandom());
    i128.sub = 1'($urandom());
    lat = 0;
    while (!i128.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("lat128", 128'(lat), 128'd4);
    if (stall > 0) begin
      repeat (stall) begin @(posedge clk); #1; end
      i128.out_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic sub, input int stall, input bit pulse);
    int   g;
    int   lat;
    exp_t e;
    e = model(16, {112'd0, a}, {112'd0, b}, c, sub);
    i16.a = a; i16.b = b; i16.c = c; i16.sub = sub;
    i16.out_ready = (stall == 0);
    i16.in_valid  = 1'b1;
    g = 0;
    while (!i16.in_ready && g < 20) begin @(posedge clk); #1; g++; end
    if (g >= 20) flag_fail("in_ready16_timeout");
    q16.push_back(e);
    @(posedge clk); #1;
    i16.in_valid = pulse;
    i16.a = 16'($urandom());
    i16.b = 16'($urandom());
    lat = 0;
    while (!i16.out_valid && lat < 20) begin
      @(posedge clk); #1;
      i16.in_valid = 1'b0;
      lat++;
      if (!i16.out_valid) check_b("in_ready16_run", i16.in_ready, 1'b0);
    end
    check("lat16", 128'(lat), 128'd4);
    if (stall > 0) begin
      repeat (stall) begin
        @(posedge clk); #1;
        check("hold_sum16", {112'd0, i16.sum}, e.sum);
        check("hold_flags16", {125'd0, i16.carry_out, i16.P_ik, i16.G_ik},
              {125'd0, e.cout, e.p, e.g});
        check_b("hold_valid16", i16.out_valid, 1'b1);
        check_b("hold_in_ready16", i16.in_ready, 1'b0);
      end
      i16.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check_b("drop_valid16", i16.out_valid, 1'b0);
    check_b("idle_in_ready16", i16.in_ready, 1'b1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic sub);
    int la;
    int lb;
    int n;
    i8a.a = a; i8a.b = b; i8a.c = c; i8a.sub = sub; i8a.out_ready = 1'b1; i8a.in_valid = 1'b1;
    i8b.a = a; i8b.b = b; i8b.c = c; i8b.sub = sub; i8b.out_ready = 1'b1; i8b.in_valid = 1'b1;
    q8a.push_back(model(8, {120'd0, a}, {120'd0, b}, c, sub));
    q8b.push_back(model(8, {120'd0, a}, {120'd0, b}, c, sub));
    @(posedge clk); #1;
    i8a.in_valid = 1'b0;
    i8b.in_valid = 1'b0;
    la = -1; lb = -1; n = 0;
    while ((la < 0 || lb < 0) && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (la < 0 && i8a.out_valid) la = n;
      if (lb < 0 && i8b.out_valid) lb = n;
    end
    check("lat8a", 128'(la), 128'd1);
    check("lat8b", 128'(lb), 128'd8);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [127:0] ra;
    logic [127:0] rb;
    logic         rc;
    logic         rs;
    i128.in_valid = 0; i128.a = '0; i128.b = '0; i128.c = 0; i128.sub = 0; i128.out_ready = 1;
    i16.in_valid  = 0; i16.a  = '0; i16.b  = '0; i16.c  = 0; i16.sub  = 0; i16.out_ready  = 1;
    i8a.in_valid  = 0; i8a.a  = '0; i8a.b  = '0; i8a.c  = 0; i8a.sub  = 0; i8a.out_ready  = 1;
    i8b.in_valid  = 0; i8b.a  = '0; i8b.b  = '0; i8b.c  = 0; i8b.sub  = 0; i8b.out_ready  = 1;

    repeat (3) @(posedge clk);
    #1;
    check_b("rst_in_ready128", i128.in_ready, 1'b1);
    check_b("rst_out_valid128", i128.out_valid, 1'b0);
    check("rst_sum128", i128.sum, 128'd0);
    check("rst_flags128", {125'd0, i128.carry_out, i128.P_ik, i128.G_ik}, 128'd0);
    check_b("rst_in_ready16", i16.in_ready, 1'b1);
    check("rst_sum16", {112'd0, i16.sum}, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op16(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    op16(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    op16(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
    op16(16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b0);

    op16(16'h1234, 16'h4321, 1'b1, 1'b0, 5, 1'b1);
    repeat (6) begin
      @(posedge clk); #1;
      check_b("no_extra_result16", i16.out_valid, 1'b0);
    end

    // Abort an operation while its counter sits at 2.
    i16.a = 16'hABCD; i16.b = 16'h1357; i16.c = 1'b1; i16.sub = 1'b0; i16.in_valid = 1'b1;
    @(posedge clk); #1;
    i16.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_b("midrun_out_valid16", i16.out_valid, 1'b0);
    check_b("midrun_in_ready16", i16.in_ready, 1'b1);
    check("midrun_sum16", {112'd0, i16.sum}, 128'd0);
    check("midrun_flags16", {125'd0, i16.carry_out, i16.P_ik, i16.G_ik}, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op16(16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0);

    op128({128{1'b1}}, 128'd1, 1'b0, 1'b0, 0);
    op128(128'd0, 128'd0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 3000; i++) begin
      ra = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom()};
      rc = 1'($urandom());
      rs = 1'($urandom());
      // Steer some operands into full-propagate patterns so P_ik=1 cases occur.
      if ($urandom_range(0, 7) == 0) rb = rs ? ra : ~ra;
      op128(ra, rb, rc, rs, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    op8(8'h80, 8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      op8(8'($urandom()), 8'($urandom()), 1'($urandom()), 1'($urandom()));
    end

    repeat (4) @(posedge clk);
    #1;
    check("queues_drained", 128'(q128.size() + q16.size() + q8a.size() + q8b.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
